// File: rtl/ser16_tx.sv
// ser16_tx: framed bit-serial transmitter.
// A word accepted over valid/ready is sent as one start bit (0), WIDTH data
// bits LSB first, then one stop bit (1). Every serial bit lasts DIV clocks.
// The line idles high, and a frame can follow the previous one with no gap.
module ser16_tx #(
    parameter int WIDTH = 16,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             invert,
    input  logic             valid,
    output logic             ready,
    output logic             tx_serial,
    output logic             busy
);

    localparam int              BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [7:0]      DIV_LAST = 8'(DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nx;
    logic [7:0]       div_cnt, div_nx;
    logic [BW-1:0]    bit_cnt, bit_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic             div_last;
    logic             accept;

    assign div_last = (div_cnt == DIV_LAST);

    // Handshake and status come only from registered state, so there is no
    // combinational path from valid or data_in to any output.
    assign ready  = (state == IDLE) || ((state == STOP) && div_last);
    assign busy   = (state != IDLE);
    assign accept = valid && ready;

    // Serial line level for the current state.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first, so no
        // path through the case can leave it unassigned and infer a latch.
        tx_serial = 1'b1;
        case (state)
            START:   tx_serial = 1'b0;
            DATA:    tx_serial = shreg[0];
            default: tx_serial = 1'b1;
        endcase
    end

    // Next state, counters and shift register; an accept reloads the frame.
    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        bit_nx   = bit_cnt;
        shreg_nx = shreg;
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_nx = invert ? ~data_in : data_in;
                    div_nx   = '0;
                    bit_nx   = '0;
                    state_nx = START;
                end
            end
            START: begin
                if (div_last) begin
                    div_nx   = '0;
                    state_nx = DATA;
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end
            DATA: begin
                if (div_last) begin
                    div_nx   = '0;
                    shreg_nx = shreg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nx   = '0;
                        state_nx = STOP;
                    end else begin
                        bit_nx = bit_cnt + BW'(1);
                    end
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end
            STOP: begin
                if (div_last) begin
                    div_nx = '0;
                    bit_nx = '0;
                    if (accept) begin
                        // Back-to-back: the next start bit follows the last stop cycle.
                        shreg_nx = invert ? ~data_in : data_in;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register; reset aborts any frame and the line returns high at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            // NOTE: the shift register is cleared too, so nothing from an
            // aborted frame survives reset.
            shreg   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating
            // together from the values they held before the edge.
            state   <= state_nx;
            div_cnt <= div_nx;
            bit_cnt <= bit_nx;
            shreg   <= shreg_nx;
        end
    end

endmodule

// File: doc/ser16_tx.md
# ser16_tx

Bit-serial transmitter for 16-bit Hack words. It accepts a parallel word over a valid/ready handshake, optionally complements it bitwise, and shifts it out on a single line as a framed serial stream. The frame is: start bit, 16 data bits LSB first, stop bit. It is the sending end of the team's serial word link and feeds the matching 16-bit deserializer on the far side.

## Interface

- `WIDTH`, default 16: data word width. Frame length is WIDTH+2 bits.
- `DIV`, default 4: clock cycles per serial bit. Legal values are 1 to 255.
- `clk` in 1: single clock. All state updates on its rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `data_in` in WIDTH: word to send. Sampled only on the accept edge.
- `invert` in 1: when 1 at the accept edge, the bitwise NOT of `data_in` is sent.
- `valid` in 1: producer has a word on `data_in`.
- `ready` out 1: transmitter can accept a word this cycle.
- `tx_serial` out 1: serial line. Idles high.
- `busy` out 1: a frame is in progress (START, DATA or STOP state).

## Operation

- States are IDLE, START, DATA and STOP.
- A 2-bit state register drives an 8-bit divide counter `div_cnt` (0..DIV-1) and a 4-bit bit counter `bit_cnt` (0..WIDTH-1).
- Accept occurs on a rising edge where `valid` and `ready` are both 1. On accept:
  - the shift register loads `invert ? ~data_in : data_in`;
  - `div_cnt` and `bit_cnt` clear;
  - state moves to START.
- IDLE: `tx_serial`=1, `ready`=1, `busy`=0.
- START: `tx_serial`=0 for DIV cycles. When `div_cnt`=DIV-1, move to DATA and clear `div_cnt`.
- DATA: `tx_serial` = shift register bit 0.
  - When `div_cnt`=DIV-1, shift right by 1 and increment `bit_cnt`.
  - When `bit_cnt`=WIDTH-1 at that point, move to STOP instead.
- STOP: `tx_serial`=1 for DIV cycles. When `div_cnt`=DIV-1, one of two things happens:
  - if `valid`=1 (accept), reload the shift register and go straight to START;
  - otherwise go to IDLE.
- `ready` equals (state==IDLE) OR (state==STOP AND `div_cnt`=DIV-1). This gives gapless back-to-back frames.
- `valid` while `ready`=0 is ignored. The producer must hold the word until accepted.
- `data_in` and `invert` changes after accept have no effect on the current frame.
- `tx_serial`, `ready` and `busy` are registered or derived only from registered state. They have no combinational path from `valid` or `data_in`.
- Reset (`reset_n`=0), at any time including mid-frame:
  - state goes to IDLE and the counters and shift register clear;
  - `tx_serial`=1, `ready`=1, `busy`=0;
  - any frame in progress is aborted with no stop bit. The line simply returns high.

## Timing

- Accept on edge N: `tx_serial` falls (start bit) after edge N and `busy`=1 from then on.
- Data bit k (k=0..WIDTH-1) is driven in cycles N+DIV·(k+1) through N+DIV·(k+2)-1.
- The stop bit occupies cycles N+DIV·(WIDTH+1) through N+DIV·(WIDTH+2)-1.
- Frame length is exactly DIV·(WIDTH+2) cycles: 72 cycles for DIV=4, 18 cycles for DIV=1.
- Back-to-back case (`valid` held high): the next start bit immediately follows the last stop cycle and `busy` stays 1.
- Non-back-to-back case: IDLE lasts at least 1 cycle and `busy`=0 in that cycle.
- DIV=1: every state lasts one cycle per bit and `ready` is 1 in the single STOP cycle.

## Test plan

- Reset and idle check, DIV=4: release `reset_n` and hold `valid`=0 for 20 cycles. Required: `tx_serial`=1, `ready`=1, `busy`=0 throughout.
- Single frame, DIV=4: send `data_in`=0xA5C3 with `invert`=0. Required, each level held 4 cycles:
  - start 0;
  - data LSB first: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1;
  - stop 1;
  - total 72 cycles, then `ready` returns.
- Invert, DIV=1: send `data_in`=0x00FF with `invert`=1. Required: start 0, eight 0s, eight 1s, stop 1, 18 cycles total.
- Back-to-back, DIV=4: hold `valid`=1 with words 0x0001 then 0x8000.
  - Required: the second start bit begins in the cycle right after the first stop bit ends.
  - `busy` never drops. The line pattern is 0,1,0×15,1 | 0,0×15,1,1.
- Busy ignore: change `data_in` to 0xFFFF and pulse `valid` during DATA of a 0x0000 frame, with `ready`=0. Required: all data bits 0 and no extra frame starts.
- Reset mid-frame: assert `reset_n`=0 while at data bit 7 of 0x1234.
  - Required: `tx_serial`=1 immediately (asynchronous), `ready`=1 and `busy`=0.
  - After release, a new 0x1234 frame transmits correctly from its start bit.
